// File: rtl/dps_utim_pkg.sv
// Shared definitions for the UTIM64 compare/interrupt array: lane geometry,
// bit positions of the per-channel configuration word and the DQM lane merge.
package dps_utim_pkg;

    localparam int UTIM_LANE_W = 32;

    // Configuration word carried from the top-level decode into each channel
    localparam int CONF_W            = 4;
    localparam int CONF_ENA_BIT      = 0;
    localparam int CONF_IRQENA_BIT   = 1;
    localparam int CONF_FULLMODE_BIT = 2;
    localparam int CONF_PERIODIC_BIT = 3;

    // Select one 32-bit lane: an active-low mask bit of 0 takes the written
    // lane, a mask bit of 1 keeps the alternative lane.
    function automatic logic [UTIM_LANE_W-1:0] lane_mask_merge(
        input logic                   lane_mask_n,
        input logic [UTIM_LANE_W-1:0] wr_lane,
        input logic [UTIM_LANE_W-1:0] keep_lane
    );
        logic [UTIM_LANE_W-1:0] result_s;
        if (lane_mask_n == 1'b0) begin
            result_s = wr_lane;
        end else begin
            result_s = keep_lane;
        end
        return result_s;
    endfunction

endpackage

// File: rtl/dps_utim_cmp_channel.sv
// One compare channel: holds interval (ini), current target (counter), mode
// bits and the sticky pending flag; detects a match against the main timer
// and performs periodic reload or one-shot disarm.
module dps_utim_cmp_channel
    import dps_utim_pkg::*;
#(
    parameter  int P_WIDTH = 64,
    localparam int P_LANES = P_WIDTH / UTIM_LANE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mtimer_working,
    input  logic [P_WIDTH-1:0] mtimer_count,
    input  logic               conf_write,
    input  logic [CONF_W-1:0]  conf_word,
    input  logic               count_write,
    input  logic [P_LANES-1:0] count_dqm_n,
    input  logic [P_WIDTH-1:0] count_value,
    input  logic               irq_clear,
    output logic               pending,
    output logic [P_WIDTH-1:0] counter,
    output logic               ena,
    output logic               irqena
);

    logic               ena_r, irqena_r, fullmode_r, periodic_r, pending_r;
    logic [P_WIDTH-1:0] ini_r, counter_r;

    logic               ena_nxt_s, irqena_nxt_s, fullmode_nxt_s, periodic_nxt_s, pending_nxt_s;
    logic [P_WIDTH-1:0] ini_nxt_s, counter_nxt_s;
    logic               ini_nz_s, eq_s, match_s;

    // Compare target against main count; 32-bit mode looks at the low lane only
    always_comb begin
        ini_nz_s = 1'b0;
        eq_s     = 1'b0;
        if (fullmode_r) begin
            ini_nz_s = (ini_r != '0);
            eq_s     = (counter_r == mtimer_count);
        end else begin
            ini_nz_s = (ini_r[UTIM_LANE_W-1:0] != '0);
            eq_s     = (counter_r[UTIM_LANE_W-1:0] == mtimer_count[UTIM_LANE_W-1:0]);
        end
        match_s = mtimer_working & ena_r & ini_nz_s & eq_s;
    end

    // Next-state: a count write beats reload/disarm, a conf write beats disarm,
    // and a pending set beats a same-cycle clear
    always_comb begin
        ini_nxt_s      = ini_r;
        counter_nxt_s  = counter_r;
        ena_nxt_s      = ena_r;
        irqena_nxt_s   = irqena_r;
        fullmode_nxt_s = fullmode_r;
        periodic_nxt_s = periodic_r;
        pending_nxt_s  = pending_r;

        if (count_write) begin
            for (int l = 0; l < P_LANES; l++) begin
                ini_nxt_s[l*UTIM_LANE_W +: UTIM_LANE_W] =
                    lane_mask_merge(count_dqm_n[l], count_value[l*UTIM_LANE_W +: UTIM_LANE_W],
                                    ini_r[l*UTIM_LANE_W +: UTIM_LANE_W]);
                // A masked lane restarts from its interval
                counter_nxt_s[l*UTIM_LANE_W +: UTIM_LANE_W] =
                    lane_mask_merge(count_dqm_n[l], count_value[l*UTIM_LANE_W +: UTIM_LANE_W],
                                    ini_r[l*UTIM_LANE_W +: UTIM_LANE_W]);
            end
        end else if (match_s) begin
            if (periodic_r) begin
                counter_nxt_s = counter_r + ini_r;
            end else begin
                ena_nxt_s = 1'b0;
            end
        end else begin
            counter_nxt_s = counter_r;
        end

        if (conf_write) begin
            ena_nxt_s      = conf_word[CONF_ENA_BIT];
            irqena_nxt_s   = conf_word[CONF_IRQENA_BIT];
            fullmode_nxt_s = conf_word[CONF_FULLMODE_BIT];
            periodic_nxt_s = conf_word[CONF_PERIODIC_BIT];
        end else begin
            irqena_nxt_s = irqena_r;
        end

        if (match_s && irqena_r) begin
            pending_nxt_s = 1'b1;
        end else if (irq_clear) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_r      <= 1'b0;
            irqena_r   <= 1'b0;
            fullmode_r <= 1'b0;
            periodic_r <= 1'b0;
            pending_r  <= 1'b0;
            ini_r      <= '0;
            counter_r  <= '0;
        end else begin
            ena_r      <= ena_nxt_s;
            irqena_r   <= irqena_nxt_s;
            fullmode_r <= fullmode_nxt_s;
            periodic_r <= periodic_nxt_s;
            pending_r  <= pending_nxt_s;
            ini_r      <= ini_nxt_s;
            counter_r  <= counter_nxt_s;
        end
    end

    assign pending = pending_r;
    assign counter = counter_r;
    assign ena     = ena_r;
    assign irqena  = irqena_r;

endmodule

// File: rtl/dps_utim_cmp_array.sv
// UTIM64 multi-channel compare/interrupt unit: channel select decode,
// per-channel compare instances, read-back mux and interrupt OR-reduce.
module dps_utim_cmp_array
    import dps_utim_pkg::*;
#(
    parameter  int P_CH    = 4,
    parameter  int P_WIDTH = 64,
    localparam int P_LANES = P_WIDTH / UTIM_LANE_W,
    localparam int P_SELW  = (P_CH > 1) ? $clog2(P_CH) : 1
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iMTIMER_WORKING,
    input  logic [P_WIDTH-1:0] iMTIMER_COUNT,
    input  logic               iCONF_WRITE,
    input  logic [P_SELW-1:0]  iSEL,
    input  logic               iCONF_ENA,
    input  logic               iCONF_IRQENA,
    input  logic               iCONF_FULLMODE,
    input  logic               iCONF_PERIODIC,
    input  logic               iCOUNT_WRITE,
    input  logic [P_LANES-1:0] inCOUNT_DQM,
    input  logic [P_WIDTH-1:0] iCOUNT_COUNTER,
    input  logic [P_CH-1:0]    iIRQ_CLEAR,
    output logic [P_CH-1:0]    oPENDING,
    output logic [P_WIDTH-1:0] oRD_COUNTER,
    output logic               oRD_ENA,
    output logic               oIRQ
);

    logic [CONF_W-1:0]  conf_word_s;
    logic [P_CH-1:0]    sel_hit_s;
    logic [P_CH-1:0]    pending_vec_s;
    logic [P_CH-1:0]    irqena_vec_s;
    logic [P_CH-1:0]    ena_vec_s;
    logic [P_WIDTH-1:0] ch_counter_s [P_CH];
    logic [P_WIDTH-1:0] rd_counter_s;
    logic               rd_ena_s;

    // Pack the configuration inputs into the channel conf word
    always_comb begin
        conf_word_s                    = '0;
        conf_word_s[CONF_ENA_BIT]      = iCONF_ENA;
        conf_word_s[CONF_IRQENA_BIT]   = iCONF_IRQENA;
        conf_word_s[CONF_FULLMODE_BIT] = iCONF_FULLMODE;
        conf_word_s[CONF_PERIODIC_BIT] = iCONF_PERIODIC;
    end

    // One-hot channel select; out-of-range selects hit nothing
    always_comb begin
        sel_hit_s = '0;
        for (int c = 0; c < P_CH; c++) begin
            sel_hit_s[c] = (int'(iSEL) == c);
        end
    end

    for (genvar c = 0; c < P_CH; c++) begin : g_ch
        dps_utim_cmp_channel #(
            .P_WIDTH (P_WIDTH)
        ) u_ch (
            .clk            (iCLOCK),
            .rst_n          (inRESET),
            .mtimer_working (iMTIMER_WORKING),
            .mtimer_count   (iMTIMER_COUNT),
            .conf_write     (iCONF_WRITE & sel_hit_s[c]),
            .conf_word      (conf_word_s),
            .count_write    (iCOUNT_WRITE & sel_hit_s[c]),
            .count_dqm_n    (inCOUNT_DQM),
            .count_value    (iCOUNT_COUNTER),
            .irq_clear      (iIRQ_CLEAR[c]),
            .pending        (pending_vec_s[c]),
            .counter        (ch_counter_s[c]),
            .ena            (ena_vec_s[c]),
            .irqena         (irqena_vec_s[c])
        );
    end

    // Read-back mux: AND-OR over the one-hot select so no hit reads zero
    always_comb begin
        rd_counter_s = '0;
        rd_ena_s     = 1'b0;
        for (int c = 0; c < P_CH; c++) begin
            rd_counter_s = rd_counter_s | ({P_WIDTH{sel_hit_s[c]}} & ch_counter_s[c]);
            rd_ena_s     = rd_ena_s | (sel_hit_s[c] & ena_vec_s[c]);
        end
    end

    assign oPENDING    = pending_vec_s;
    assign oRD_COUNTER = rd_counter_s;
    assign oRD_ENA     = rd_ena_s;
    assign oIRQ        = |(pending_vec_s & irqena_vec_s);

endmodule
